// File: rtl/intra_sad_mode_sel_if.sv
// Handshake bundle for intra_sad_mode_sel: candidate residual beats in, selected mode's residual beats out.
// The master modport drives the input beats and out_ready; the slave modport is the decider.
interface intra_sad_mode_sel_if #(
  parameter int NMODES = 4,
  parameter int BLK    = 64,
  parameter int LANES  = 8,
  parameter int DW     = 8
);
  localparam int SW = DW + $clog2(BLK);
  localparam int MW = $clog2(NMODES);

  logic [NMODES-1:0]                   mode_en;
  logic                                in_valid;
  logic                                in_ready;
  logic [NMODES-1:0][LANES-1:0][DW-1:0] in_res;
  logic                                out_valid;
  logic                                out_ready;
  logic [LANES-1:0][DW-1:0]            out_res;
  logic                                out_last;
  logic [MW-1:0]                       mode;
  logic [SW-1:0]                       best_sad;

  modport master (
    output mode_en, in_valid, in_res, out_ready,
    input  in_ready, out_valid, out_res, out_last, mode, best_sad
  );

  modport slave (
    input  mode_en, in_valid, in_res, out_ready,
    output in_ready, out_valid, out_res, out_last, mode, best_sad
  );
endinterface

// File: rtl/intra_sad_mode_sel.sv
// Streaming SAD mode decider: accumulate per-mode SAD, pick cheapest, replay its block (out_valid 2 edges after last beat).
// Input is held off (in_ready=0) while deciding and draining; `define INTRA_SAD_MODE_MASK_EN to honour mode_en.
module intra_sad_mode_sel #(
  parameter int NMODES = 4,
  parameter int BLK    = 64,
  parameter int LANES  = 8,
  parameter int DW     = 8
) (
  input logic             clk_i,
  input logic             reset_ni,
  intra_sad_mode_sel_if.slave bus
);
  localparam int BEATS = BLK / LANES;
  localparam int SW    = DW + $clog2(BLK);
  localparam int MW    = $clog2(NMODES);
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {ACCUM, DECIDE, DRAIN} state_t;

  state_t                              state_q;
  logic [BCW-1:0]                      beat_cnt_q;
  logic [BCW-1:0]                      rd_cnt_q;
  logic [SW-1:0]                       sad_q [NMODES];
  logic [MW-1:0]                       mode_q;
  logic [SW-1:0]                       best_sad_q;
  logic [LANES-1:0][DW-1:0]            out_res_q;
  logic                                out_valid_q;
  logic                                out_last_q;
  logic [NMODES-1:0][LANES-1:0][DW-1:0] buf_q [BEATS];

  logic [SW-1:0]     beat_sum [NMODES];
  logic [NMODES-1:0] en_eff;
  logic [MW-1:0]     mode_d;
  logic [SW-1:0]     best_sad_d;
  logic              sel_found;
  logic              accept;
  logic              first_beat;
  logic              last_beat;

`ifdef INTRA_SAD_MODE_MASK_EN
  logic [NMODES-1:0] mask_q;
  assign en_eff = mask_q;
`else
  logic unused_mode_en;
  assign en_eff         = '1;
  assign unused_mode_en = ^bus.mode_en;
`endif

  // Magnitude kept unsigned at DW bits so the most negative value maps to 2^(DW-1).
  function automatic logic [DW-1:0] abs_dw(input logic [DW-1:0] x);
    return x[DW-1] ? (~x + DW'(1)) : x;
  endfunction

  assign bus.in_ready = reset_ni && (state_q == ACCUM);
  assign accept       = bus.in_valid && bus.in_ready;
  assign first_beat   = (beat_cnt_q == '0);
  assign last_beat    = (beat_cnt_q == BCW'(BEATS - 1));

  always_comb begin
    for (int m = 0; m < NMODES; m++) begin
      beat_sum[m] = '0;
      for (int l = 0; l < LANES; l++) begin
        beat_sum[m] = beat_sum[m] + SW'(abs_dw(bus.in_res[m][l]));
      end
    end
  end

  // Strict '<' scan: lowest index wins ties; an empty mask falls back to mode 0.
  always_comb begin
    sel_found  = 1'b0;
    mode_d     = '0;
    best_sad_d = sad_q[0];
    for (int m = 0; m < NMODES; m++) begin
      if (en_eff[m] && (!sel_found || (sad_q[m] < best_sad_d))) begin
        sel_found  = 1'b1;
        mode_d     = MW'(m);
        best_sad_d = sad_q[m];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      buf_q[beat_cnt_q] <= bus.in_res;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= ACCUM;
      beat_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      mode_q      <= '0;
      best_sad_q  <= '0;
      out_res_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int m = 0; m < NMODES; m++) sad_q[m] <= '0;
`ifdef INTRA_SAD_MODE_MASK_EN
      mask_q      <= '0;
`endif
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            for (int m = 0; m < NMODES; m++) begin
              sad_q[m] <= first_beat ? beat_sum[m] : (sad_q[m] + beat_sum[m]);
            end
`ifdef INTRA_SAD_MODE_MASK_EN
            if (first_beat) mask_q <= bus.mode_en;
`endif
            if (last_beat) begin
              beat_cnt_q <= '0;
              state_q    <= DECIDE;
            end else begin
              beat_cnt_q <= beat_cnt_q + BCW'(1);
            end
          end
        end
        DECIDE: begin
          mode_q      <= mode_d;
          best_sad_q  <= best_sad_d;
          out_res_q   <= buf_q[BCW'(0)][mode_d];
          out_valid_q <= 1'b1;
          out_last_q  <= (BEATS == 1);
          rd_cnt_q    <= '0;
          state_q     <= DRAIN;
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (rd_cnt_q == BCW'(BEATS - 1)) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              rd_cnt_q    <= '0;
              state_q     <= ACCUM;
            end else begin
              rd_cnt_q   <= rd_cnt_q + BCW'(1);
              out_res_q  <= buf_q[rd_cnt_q + BCW'(1)][mode_q];
              out_last_q <= ((rd_cnt_q + BCW'(1)) == BCW'(BEATS - 1));
            end
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_res   = out_res_q;
  assign bus.out_last  = out_last_q;
  assign bus.mode      = mode_q;
  assign bus.best_sad  = best_sad_q;
endmodule

// File: tb/tb_intra_sad_mode_sel.sv
// Scoreboard bench for intra_sad_mode_sel: stimulus pushes expected output beats, a monitor pops and compares.
module tb_intra_sad_mode_sel;
  localparam int NMODES = 4;
  localparam int BLK    = 64;
  localparam int LANES  = 8;
  localparam int DW     = 8;
  localparam int BEATS  = BLK / LANES;

  typedef logic [LANES-1:0][DW-1:0] beat_t;
  typedef struct {
    beat_t res;
    bit    last;
    int    mode;
    int    sad;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   dat [NMODES][BLK];
  exp_t expq [$];
  int   rdy_mode = 0;
  int   gap_pct = 0;
  int   beats_seen = 0;
  int   beats_pushed = 0;

  intra_sad_mode_sel_if #(.NMODES(NMODES), .BLK(BLK), .LANES(LANES), .DW(DW)) bus ();

  intra_sad_mode_sel #(.NMODES(NMODES), .BLK(BLK), .LANES(LANES), .DW(DW)) dut (
    .clk_i   (clk),
    .reset_ni(reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: total |x| per mode, cheapest enabled mode (lowest index on ties), mode 0 if none enabled.
  function automatic void push_expected(input logic [NMODES-1:0] en);
    int sum [NMODES];
    logic [NMODES-1:0] eff;
    int best;
    int min_sad;
    exp_t e;
`ifdef INTRA_SAD_MODE_MASK_EN
    eff = en;
`else
    eff = '1;
`endif
    min_sad = -1;
    for (int m = 0; m < NMODES; m++) begin
      sum[m] = 0;
      for (int s = 0; s < BLK; s++) sum[m] += (dat[m][s] < 0) ? -dat[m][s] : dat[m][s];
      if (eff[m] && (min_sad < 0 || sum[m] < min_sad)) min_sad = sum[m];
    end
    best = 0;
    for (int m = NMODES - 1; m >= 0; m--) begin
      if (eff[m] && sum[m] == min_sad) best = m;
    end
    for (int b = 0; b < BEATS; b++) begin
      for (int l = 0; l < LANES; l++) e.res[l] = DW'(dat[best][b*LANES + l]);
      e.last = (b == BEATS - 1);
      e.mode = best;
      e.sad  = sum[best];
      expq.push_back(e);
      beats_pushed++;
    end
  endfunction

  function automatic void fill_const(input int m, input int v);
    for (int s = 0; s < BLK; s++) dat[m][s] = v;
  endfunction

  function automatic void fill_random();
    for (int m = 0; m < NMODES; m++) begin
      int amp = int'($urandom_range(1, 128));
      for (int s = 0; s < BLK; s++) begin
        int v = int'($urandom_range(0, 2 * amp)) - amp;
        dat[m][s] = (v > 127) ? 127 : v;
      end
    end
  endfunction

  // Feeds n beats; returns after the negedge preceding the acceptance edge of the last one.
  task automatic send_beats(input logic [NMODES-1:0] en, input int n);
    int b = 0;
    int cyc = 0;
    while (b < n && cyc < 4000) begin
      @(posedge clk); #1;
      if (b > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.mode_en  = (b == 0) ? en : NMODES'($urandom);
        for (int m = 0; m < NMODES; m++)
          for (int l = 0; l < LANES; l++) bus.in_res[m][l] = DW'(dat[m][b*LANES + l]);
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) b++;
      cyc++;
    end
    if (b < n) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: accepted %0d beats, required %0d", b, n);
    end
  endtask

  task automatic send_block(input logic [NMODES-1:0] en, input bit chk_lat);
    push_expected(en);
    send_beats(en, BEATS);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (chk_lat) begin
      @(negedge clk);
      chk("lat_decide_valid", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
      chk("lat_first_valid", 64'(bus.out_valid), 64'd1);
    end
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while (expq.size() != 0 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    chk("drain_queue_empty", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    bit    stall = 1'b0;
    beat_t pres;
    bit    plast;
    exp_t  e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("stall_valid", 64'(bus.out_valid), 64'd1);
          chk("stall_res", 64'(bus.out_res), 64'(pres));
          chk("stall_last", 64'(bus.out_last), 64'(plast));
        end
        if (bus.out_valid) chk("in_ready_drain", 64'(bus.in_ready), 64'd0);
        if (bus.out_valid && bus.out_ready) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got res 0x%0h, required no output", bus.out_res);
          end else begin
            e = expq.pop_front();
            chk("out_res", 64'(bus.out_res), 64'(e.res));
            chk("out_last", 64'(bus.out_last), 64'(e.last));
            chk("mode", 64'(bus.mode), 64'(e.mode));
            chk("best_sad", 64'(bus.best_sad), 64'(e.sad));
            beats_seen++;
          end
        end
        stall = bus.out_valid && !bus.out_ready;
        pres  = bus.out_res;
        plast = bus.out_last;
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_res   = '0;
    bus.mode_en  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_mode", 64'(bus.mode), 64'd0);
    chk("rst_best_sad", 64'(bus.best_sad), 64'd0);
    chk("rst_out_res", 64'(bus.out_res), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 64'(bus.in_ready), 64'd1);

    for (int m = 0; m < NMODES; m++) fill_const(m, (m == 2) ? 0 : 1);
    send_block('1, 1'b1);
    wait_drain();

    for (int m = 0; m < NMODES; m++) fill_const(m, -3);
    send_block('1, 1'b1);
    wait_drain();

    for (int m = 0; m < NMODES; m++) fill_const(m, (m == 1) ? -128 : 127);
    send_block('1, 1'b1);
    send_block(NMODES'(4'b1110), 1'b1);
    wait_drain();

    for (int m = 0; m < NMODES; m++) fill_const(m, (m == 3) ? 0 : 5);
    send_block('0, 1'b1);
    wait_drain();

    gap_pct  = 30;
    rdy_mode = 1;
    for (int k = 0; k < 3; k++) begin
      fill_random();
      send_block(NMODES'($urandom), 1'b1);
    end
    rdy_mode = 2;
    for (int k = 0; k < 3; k++) begin
      fill_random();
      send_block(NMODES'($urandom), 1'b1);
    end
    wait_drain();
    chk("beat_count", 64'(beats_seen), 64'(beats_pushed));

    gap_pct  = 0;
    rdy_mode = 0;
    fill_random();
    send_beats('1, 5);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    for (int m = 0; m < NMODES; m++)
      for (int l = 0; l < LANES; l++) bus.in_res[m][l] = DW'(dat[m][5*LANES + l]);
    reset_n = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", 64'(bus.in_ready), 64'd0);
    chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_rel_in_ready", 64'(bus.in_ready), 64'd1);
    fill_random();
    send_block('1, 1'b1);
    wait_drain();
    chk("final_beat_count", 64'(beats_seen), 64'(beats_pushed));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
